modulo_updown_counter: RTL and testbench
========================================

// Module: modulo_updown_counter
// PURPOSE
//  Parametrised up/down counter with programmable modulus, tick-gated stepping,
//  synchronous clear/load and registered carry/borrow pulses for cascading.
//  Building block for the clock datapath: seconds/minutes (mod 60) and hours (mod 24).
//  Chaining: carry/borrow of stage k drives tick of stage k+1.
// PARAMETERS
//  BITS      8   width of count value
//  MODULUS   60  count range 0..MODULUS-1; legal 2..2**BITS (elaboration error otherwise)
//  SATURATE  0   0: wrap at limits; 1: hold at limits, no carry/borrow
// PORTS
//  clk         in   1     system clock, all state on rising edge
//  rst         in   1     asynchronous, active-low reset
//  start       in   1     1 run, 0 stop (hold value)
//  forward     in   1     1 count up, 0 count down
//  tick        in   1     step strobe; one step per cycle with tick=1
//  clear       in   1     synchronous clear to 0
//  load        in   1     synchronous load of load_value
//  load_value  in   BITS  value for load
//  number      out  BITS  current count, always in 0..MODULUS-1
//  carry       out  1     1-cycle pulse: up-count wrapped MODULUS-1 -> 0
//  borrow      out  1     1-cycle pulse: down-count wrapped 0 -> MODULUS-1
//  at_limit    out  1     1 when number is at the terminal value for current direction
// BEHAVIOUR
//  - Reset (rst=0, async): number=0, carry=0, borrow=0. Held while rst=0; release sync to clk.
//  - Per-cycle priority: clear > load > step > hold.
//  - clear=1: number<=0 next edge; carry/borrow<=0.
//  - load=1: number<=load_value; if load_value>=MODULUS, number<=MODULUS-1. No carry/borrow.
//  - step = start & tick. Stop (start=0) or tick=0: number held, carry/borrow<=0.
//  - Up step: number<MODULUS-1 -> +1; number==MODULUS-1 -> 0 with carry<=1
//    (SATURATE=1: stays at MODULUS-1, carry stays 0).
//  - Down step: number>0 -> -1; number==0 -> MODULUS-1 with borrow<=1
//    (SATURATE=1: stays 0, borrow stays 0).
//  - Latency: number, carry and borrow update on the same edge as the step; 1 cycle from tick.
//  - carry and borrow are registered and are never both 1.
//    Each deasserts on the following edge unless another wrapping step occurs.
//  - forward may change on any cycle; the value sampled on the step cycle applies.
//  - at_limit is combinational from registers and current forward:
//    forward=1 -> number==MODULUS-1; forward=0 -> number==0.
//  - Arithmetic is computed in BITS+1 bits. MODULUS==2**BITS wraps naturally with no overflow glitch.
//  - number never leaves 0..MODULUS-1 under any input sequence.
//  - Reset mid-count: immediate 0, pending carry/borrow pulse dropped.
// TESTING
//  1. Reset: rst=0 asynchronously mid-cycle at number=37 -> number=0, carry=0 before next edge.
//  2. Wrap up (MODULUS=60): load 58, start=1, forward=1, tick every cycle
//     -> 59, 0 (carry=1 one cycle), 1; carry=0 after.
//  3. Wrap down (MODULUS=24): load 1, forward=0, 3 ticks
//     -> 0, 23 (borrow=1 one cycle), 22.
//  4. Gating: start=0 with tick=1 for 5 cycles at 10 -> holds 10.
//     start=1, tick every 4th cycle -> +1 per tick only.
//  5. Priority and clamp: clear=1,load=1,tick=1 same cycle -> 0.
//     load_value=200 at MODULUS=60 -> number=59.
//  6. SATURATE=1: at 59 up-tick x3 -> stays 59, carry never 1, at_limit=1.
//     Cascade sec->min chain from 59:59 with one tick -> 00:00, minute carry pulse.

Source files
------------

// File: rtl/modulo_updown_counter.sv
// Modulo-N up/down counter with tick-gated stepping, synchronous clear/load,
// and registered carry/borrow pulses so stages can be chained carry -> tick.
module modulo_updown_counter #(
  parameter int BITS     = 8,
  parameter int MODULUS  = 60,
  parameter bit SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            forward,
  input  logic            tick,
  input  logic            clear,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] number,
  output logic            carry,
  output logic            borrow,
  output logic            at_limit
);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** BITS)) begin : g_bad_modulus
      $error("modulo_updown_counter: MODULUS must be within 2..2**BITS");
    end
  endgenerate

  // Everything is compared one bit wider so MODULUS == 2**BITS is representable.
  localparam logic [BITS:0] MOD_W = (BITS+1)'(MODULUS);
  localparam logic [BITS:0] MAX_W = (BITS+1)'(MODULUS - 1);
  localparam logic [BITS:0] ONE_W = (BITS+1)'(1);

  logic [BITS-1:0] number_q, number_d;
  logic            carry_q,  carry_d;
  logic            borrow_q, borrow_d;

  logic [BITS:0] num_ext, inc_ext, dec_ext, load_ext;
  logic          step, wrap_up, wrap_dn;

  always_comb begin
    num_ext  = {1'b0, number_q};
    inc_ext  = num_ext + ONE_W;
    dec_ext  = num_ext - ONE_W;
    load_ext = {1'b0, load_value};
    step     = start & tick;
    wrap_up  = (inc_ext == MOD_W);
    // Decrementing zero borrows out of the extension bit.
    wrap_dn  = dec_ext[BITS];

    number_d = number_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;

    if (clear) begin
      number_d = '0;
    end else if (load) begin
      number_d = (load_ext >= MOD_W) ? MAX_W[BITS-1:0] : load_value;
    end else if (step) begin
      if (forward) begin
        if (!wrap_up) begin
          number_d = inc_ext[BITS-1:0];
        end else if (!SATURATE) begin
          number_d = '0;
          carry_d  = 1'b1;
        end
      end else begin
        if (!wrap_dn) begin
          number_d = dec_ext[BITS-1:0];
        end else if (!SATURATE) begin
          number_d = MAX_W[BITS-1:0];
          borrow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      number_q <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      number_q <= number_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign number   = number_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign at_limit = forward ? (num_ext == MAX_W) : (number_q == '0);

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Directed bench: table of per-cycle vectors on a mod-60 counter, plus short
// sequences for mod-24 borrow, saturation, full-range mod-16, cascade and reset.
module tb_modulo_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // mod-60 wrapping counter (table driven)
  logic       a_st, a_fw, a_tk, a_clr, a_ld;
  logic [7:0] a_lv, a_num;
  logic       a_c, a_b, a_lim;
  modulo_updown_counter #(.BITS(8), .MODULUS(60), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(a_st), .forward(a_fw), .tick(a_tk),
    .clear(a_clr), .load(a_ld), .load_value(a_lv),
    .number(a_num), .carry(a_c), .borrow(a_b), .at_limit(a_lim));

  // mod-24 wrapping counter
  logic       h_st, h_fw, h_tk, h_clr, h_ld;
  logic [7:0] h_lv, h_num;
  logic       h_c, h_b, h_lim;
  modulo_updown_counter #(.BITS(8), .MODULUS(24), .SATURATE(1'b0)) u_h (
    .clk(clk), .rst(rst), .start(h_st), .forward(h_fw), .tick(h_tk),
    .clear(h_clr), .load(h_ld), .load_value(h_lv),
    .number(h_num), .carry(h_c), .borrow(h_b), .at_limit(h_lim));

  // mod-60 saturating counter
  logic       s_st, s_fw, s_tk, s_clr, s_ld;
  logic [7:0] s_lv, s_num;
  logic       s_c, s_b, s_lim;
  modulo_updown_counter #(.BITS(8), .MODULUS(60), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst(rst), .start(s_st), .forward(s_fw), .tick(s_tk),
    .clear(s_clr), .load(s_ld), .load_value(s_lv),
    .number(s_num), .carry(s_c), .borrow(s_b), .at_limit(s_lim));

  // full-range counter: MODULUS == 2**BITS
  logic       w_st, w_fw, w_tk, w_clr, w_ld;
  logic [3:0] w_lv, w_num;
  logic       w_c, w_b, w_lim;
  modulo_updown_counter #(.BITS(4), .MODULUS(16), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst(rst), .start(w_st), .forward(w_fw), .tick(w_tk),
    .clear(w_clr), .load(w_ld), .load_value(w_lv),
    .number(w_num), .carry(w_c), .borrow(w_b), .at_limit(w_lim));

  // seconds -> minutes cascade
  logic       k_tk, k_ld;
  logic [7:0] k_lv, sec_num, min_num;
  logic       sec_c, sec_b, sec_lim, min_c, min_b, min_lim;
  modulo_updown_counter #(.BITS(8), .MODULUS(60), .SATURATE(1'b0)) u_sec (
    .clk(clk), .rst(rst), .start(1'b1), .forward(1'b1), .tick(k_tk),
    .clear(1'b0), .load(k_ld), .load_value(k_lv),
    .number(sec_num), .carry(sec_c), .borrow(sec_b), .at_limit(sec_lim));
  modulo_updown_counter #(.BITS(8), .MODULUS(60), .SATURATE(1'b0)) u_min (
    .clk(clk), .rst(rst), .start(1'b1), .forward(1'b1), .tick(sec_c),
    .clear(1'b0), .load(k_ld), .load_value(k_lv),
    .number(min_num), .carry(min_c), .borrow(min_b), .at_limit(min_lim));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       clr, ld;
    logic [7:0] lv;
    logic       st, fw, tk;
    logic [7:0] num;
    logic       c, b, lim;
  } vec_t;

  vec_t tv[$];

  initial begin
    //            clr   ld    lv      st    fw    tk     num    c     b     lim
    tv.push_back('{1'b0, 1'b1, 8'd58,  1'b0, 1'b1, 1'b0, 8'd58, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd59, 1'b0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd0,  1'b1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd1,  1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'd10,  1'b1, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++)
      tv.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0});
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 3; i++)
        tv.push_back('{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'(10 + t), 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'(11 + t), 1'b0, 1'b0, 1'b0});
    end
    tv.push_back('{1'b1, 1'b1, 8'd30,  1'b1, 1'b1, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'd200, 1'b0, 1'b1, 1'b0, 8'd59, 1'b0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd59, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 8'd59, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 8'd58, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'd60,  1'b0, 1'b1, 1'b0, 8'd59, 1'b0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd0,  1'b1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'd59,  1'b1, 1'b1, 1'b1, 8'd59, 1'b0, 1'b0, 1'b1});
    tv.push_back('{1'b1, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 8'd59, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd0,  1'b1, 1'b0, 1'b0});

    {a_st, a_fw, a_tk, a_clr, a_ld, a_lv} = '0;
    {h_st, h_fw, h_tk, h_clr, h_ld, h_lv} = '0;
    {s_st, s_fw, s_tk, s_clr, s_ld, s_lv} = '0;
    {w_st, w_fw, w_tk, w_clr, w_ld, w_lv} = '0;
    {k_tk, k_ld, k_lv} = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("reset num", 32'(a_num), 0);
    chk("reset carry", 32'(a_c), 0);
    chk("reset borrow", 32'(a_b), 0);
    chk("reset num24", 32'(h_num), 0);

    foreach (tv[i]) begin
      a_clr = tv[i].clr; a_ld = tv[i].ld; a_lv = tv[i].lv;
      a_st = tv[i].st; a_fw = tv[i].fw; a_tk = tv[i].tk;
      cyc();
      chk($sformatf("vec%0d num", i), 32'(a_num), 32'(tv[i].num));
      chk($sformatf("vec%0d carry", i), 32'(a_c), 32'(tv[i].c));
      chk($sformatf("vec%0d borrow", i), 32'(a_b), 32'(tv[i].b));
      chk($sformatf("vec%0d at_limit", i), 32'(a_lim), 32'(tv[i].lim));
    end
    {a_st, a_tk, a_clr, a_ld} = '0;

    // mod-24 borrow: 1 -> 0 -> 23 -> 22
    h_ld = 1'b1; h_lv = 8'd1; cyc(); h_ld = 1'b0;
    chk("h load", 32'(h_num), 1);
    h_st = 1'b1; h_fw = 1'b0; h_tk = 1'b1;
    cyc(); chk("h step1", 32'(h_num), 0);  chk("h b1", 32'(h_b), 0); chk("h lim0", 32'(h_lim), 1);
    cyc(); chk("h step2", 32'(h_num), 23); chk("h b2", 32'(h_b), 1); chk("h c2", 32'(h_c), 0);
    cyc(); chk("h step3", 32'(h_num), 22); chk("h b3", 32'(h_b), 0);
    h_tk = 1'b0;

    // saturation at both limits
    s_ld = 1'b1; s_lv = 8'd59; s_fw = 1'b1; cyc(); s_ld = 1'b0;
    s_st = 1'b1; s_tk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sat up num", 32'(s_num), 59);
      chk("sat up carry", 32'(s_c), 0);
      chk("sat up lim", 32'(s_lim), 1);
    end
    s_ld = 1'b1; s_lv = 8'd0; s_fw = 1'b0; s_tk = 1'b0; cyc(); s_ld = 1'b0;
    s_tk = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("sat dn num", 32'(s_num), 0);
      chk("sat dn borrow", 32'(s_b), 0);
    end
    s_tk = 1'b0;

    // full-range 4-bit: 15 -> 0 carry, 0 -> 15 borrow, clamp-free load of 15
    w_ld = 1'b1; w_lv = 4'd15; w_fw = 1'b1; cyc(); w_ld = 1'b0;
    chk("w load15", 32'(w_num), 15); chk("w lim15", 32'(w_lim), 1);
    w_st = 1'b1; w_tk = 1'b1;
    cyc(); chk("w wrap up", 32'(w_num), 0);  chk("w carry", 32'(w_c), 1);
    w_fw = 1'b0;
    cyc(); chk("w wrap dn", 32'(w_num), 15); chk("w borrow", 32'(w_b), 1); chk("w carry off", 32'(w_c), 0);
    cyc(); chk("w dn14", 32'(w_num), 14);  chk("w borrow off", 32'(w_b), 0);
    w_tk = 1'b0;

    // cascade 59:59 + one second tick -> 00:00, minute carry follows a cycle later
    k_ld = 1'b1; k_lv = 8'd59; cyc(); k_ld = 1'b0;
    k_tk = 1'b1; cyc(); k_tk = 1'b0;
    chk("casc sec", 32'(sec_num), 0); chk("casc sec carry", 32'(sec_c), 1);
    chk("casc min hold", 32'(min_num), 59);
    cyc();
    chk("casc min", 32'(min_num), 0); chk("casc min carry", 32'(min_c), 1);
    chk("casc sec carry off", 32'(sec_c), 0);
    cyc();
    chk("casc min carry off", 32'(min_c), 0); chk("casc sec hold", 32'(sec_num), 0);

    // async reset mid-cycle at 37
    a_ld = 1'b1; a_lv = 8'd37; cyc(); a_ld = 1'b0;
    chk("pre-reset 37", 32'(a_num), 37);
    #2 rst = 1'b0;
    #1;
    chk("async rst num", 32'(a_num), 0);
    chk("async rst carry", 32'(a_c), 0);
    @(negedge clk) rst = 1'b1;

    // reset drops a pending carry pulse
    a_ld = 1'b1; a_lv = 8'd59; a_fw = 1'b1; cyc(); a_ld = 1'b0;
    a_st = 1'b1; a_tk = 1'b1; cyc(); a_tk = 1'b0;
    chk("pend carry", 32'(a_c), 1);
    #2 rst = 1'b0;
    #1;
    chk("rst drops carry", 32'(a_c), 0);
    chk("rst num0", 32'(a_num), 0);
    @(negedge clk) rst = 1'b1;
    cyc();
    chk("post-rst hold", 32'(a_num), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
